// File: rtl/uart_alu_ctrl.sv
// ---------------------------------------------------------------------------
// uart_alu_ctrl
// Sequences a UART-driven ALU command: three received bytes (operand A,
// operand B, opcode) are captured, the combinational ALU result is
// registered, a transmit request is pulsed and the block waits for the
// transmitter to finish before accepting the next command.
//
// Optional feature: define UART_ALU_CTRL_TIMEOUT_EN to abort a partially
// received command after TIMEOUT_TICKS baud ticks without a byte in
// WAIT_B / WAIT_OP. Without it o_timeout is tied low and the wait states
// wait indefinitely; the port list is unchanged.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   i_tick        baud tick (one clk wide)
//   i_rx_done     received-byte strobe, i_rx_data valid with it
//   i_rx_data     received byte
//   i_alu_result  combinational ALU output for o_data_a/o_data_b/o_opcode
//   i_tx_done     transmitter frame-complete strobe
//   o_data_a      registered operand A
//   o_data_b      registered operand B
//   o_opcode      registered opcode (low OPBITS of the third byte)
//   o_tx_data     registered ALU result for the transmitter
//   o_tx_start    one-cycle transmit request
//   o_busy        high while computing, sending or waiting for the transmitter
//   o_timeout     one-cycle pulse when a timeout aborts a command
// ---------------------------------------------------------------------------
module uart_alu_ctrl #(
  parameter int NBITS         = 8,
  parameter int OPBITS        = 6,
  parameter int TIMEOUT_TICKS = 704
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick,
  input  logic              i_rx_done,
  input  logic [NBITS-1:0]  i_rx_data,
  input  logic [NBITS-1:0]  i_alu_result,
  input  logic              i_tx_done,
  output logic [NBITS-1:0]  o_data_a,
  output logic [NBITS-1:0]  o_data_b,
  output logic [OPBITS-1:0] o_opcode,
  output logic [NBITS-1:0]  o_tx_data,
  output logic              o_tx_start,
  output logic              o_busy,
  output logic              o_timeout
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t state_r;
  state_t next_state_s;
  logic   timeout_hit_s;
  logic   next_busy_s;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

  logic [CNT_W-1:0] tick_cnt_r;
  logic             in_wait_s;

  assign in_wait_s = (state_r == WAIT_B) || (state_r == WAIT_OP);

  // The terminal tick is the one that would bring the count to
  // TIMEOUT_TICKS; a byte arriving on that same cycle takes priority.
  assign timeout_hit_s = in_wait_s && i_tick && !i_rx_done &&
                         (tick_cnt_r == CNT_W'(TIMEOUT_TICKS - 1));

  // Inter-byte tick counter, restarted on every state change or accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_r <= '0;
    end else if ((next_state_s != state_r) || i_rx_done) begin
      tick_cnt_r <= '0;
    end else if (in_wait_s && i_tick) begin
      tick_cnt_r <= tick_cnt_r + CNT_W'(1);
    end
  end
`else
  logic unused_s;

  assign timeout_hit_s = 1'b0;
  assign unused_s      = i_tick & (TIMEOUT_TICKS > 0);
`endif

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_rx_done) next_state_s = WAIT_B;
        else           next_state_s = IDLE;
      end
      WAIT_B: begin
        if (i_rx_done)          next_state_s = WAIT_OP;
        else if (timeout_hit_s) next_state_s = IDLE;
        else                    next_state_s = WAIT_B;
      end
      WAIT_OP: begin
        if (i_rx_done)          next_state_s = CALC;
        else if (timeout_hit_s) next_state_s = IDLE;
        else                    next_state_s = WAIT_OP;
      end
      CALC:    next_state_s = SEND;
      SEND:    next_state_s = WAIT_TX;
      WAIT_TX: begin
        // Bytes arriving here are dropped, even alongside i_tx_done.
        if (i_tx_done) next_state_s = IDLE;
        else           next_state_s = WAIT_TX;
      end
      default: next_state_s = IDLE;
    endcase
  end

  assign next_busy_s = (next_state_s == CALC) || (next_state_s == SEND) ||
                       (next_state_s == WAIT_TX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand, opcode and result capture; values persist across commands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data_a  <= '0;
      o_data_b  <= '0;
      o_opcode  <= '0;
      o_tx_data <= '0;
    end else begin
      if ((state_r == IDLE) && i_rx_done)    o_data_a  <= i_rx_data;
      if ((state_r == WAIT_B) && i_rx_done)  o_data_b  <= i_rx_data;
      if ((state_r == WAIT_OP) && i_rx_done) o_opcode  <= i_rx_data[OPBITS-1:0];
      if (state_r == CALC)                   o_tx_data <= i_alu_result;
    end
  end

  // Registered status strobes; SEND and a timeout last one cycle, so
  // neither strobe can stay high on consecutive cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_tx_start <= (state_r == SEND);
      o_timeout  <= timeout_hit_s;
      o_busy     <= next_busy_s;
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_alu_ctrl
// Self-checking bench for uart_alu_ctrl (TIMEOUT_TICKS = 8). A transaction
// level model tracks how many command bytes have arrived, how long ago the
// opcode arrived and how many ticks have elapsed since the last byte, and
// from that derives every output; a compare process checks the DUT against
// it after every clock edge. Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_uart_alu_ctrl;

  localparam int T_TICKS = 8;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] alu_result;
  logic       tx_done = 1'b0;
  logic [7:0] data_a, data_b, tx_data;
  logic [5:0] opcode;
  logic       tx_start, busy, timeout;

  int checks = 0;
  int failures = 0;

  uart_alu_ctrl #(.NBITS(8), .OPBITS(6), .TIMEOUT_TICKS(T_TICKS)) dut (
    .clk(clk), .rst(rst), .i_tick(tick), .i_rx_done(rx_done),
    .i_rx_data(rx_data), .i_alu_result(alu_result), .i_tx_done(tx_done),
    .o_data_a(data_a), .o_data_b(data_b), .o_opcode(opcode),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // Bench ALU
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   alu_f = a + b;
      6'h22:   alu_f = a - b;
      6'h24:   alu_f = a & b;
      6'h25:   alu_f = a | b;
      6'h26:   alu_f = a ^ b;
      default: alu_f = ~(a | b);
    endcase
  endfunction

  assign alu_result = alu_f(data_a, data_b, opcode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  logic       m_start, m_to, m_busy;
  int         m_nbytes;   // bytes of the current command received so far
  int         m_since;    // edges since the opcode was accepted
  int         m_ticks;    // ticks since the last accepted byte

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a = 8'h00; m_b = 8'h00; m_tx = 8'h00; m_op = 6'h00;
      m_start = 1'b0; m_to = 1'b0; m_busy = 1'b0;
      m_nbytes = 0; m_since = 0; m_ticks = 0;
    end else begin
      m_start = 1'b0;
      m_to = 1'b0;
      if (!m_busy) begin
        if (rx_done) begin
          if (m_nbytes == 0)      m_a = rx_data;
          else if (m_nbytes == 1) m_b = rx_data;
          else                    m_op = rx_data[5:0];
          m_ticks = 0;
          if (m_nbytes == 2) begin
            m_nbytes = 0; m_busy = 1'b1; m_since = 0;
          end else begin
            m_nbytes++;
          end
        end else if (TO_EN && m_nbytes > 0 && tick) begin
          m_ticks++;
          if (m_ticks == T_TICKS) begin
            m_to = 1'b1; m_nbytes = 0; m_ticks = 0;
          end
        end
      end else begin
        // First edge after the opcode computes, second requests transmit,
        // later edges wait for the transmitter.
        if (m_since == 0) m_tx = alu_f(m_a, m_b, m_op);
        if (m_since == 1) m_start = 1'b1;
        if (m_since >= 2 && tx_done) m_busy = 1'b0;
        m_since++;
      end
    end
  end

  // Compare process: one step after every active edge
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("data_a", {24'd0, data_a}, {24'd0, m_a});
      chk("data_b", {24'd0, data_b}, {24'd0, m_b});
      chk("opcode", {26'd0, opcode}, {26'd0, m_op});
      chk("tx_data", {24'd0, tx_data}, {24'd0, m_tx});
      chk("tx_start", {31'd0, tx_start}, {31'd0, m_start});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("timeout", {31'd0, timeout}, {31'd0, m_to});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic rx, input logic [7:0] d, input logic tk, input logic td);
    @(negedge clk);
    rx_done = rx; rx_data = d; tick = tk; tx_done = td;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, op, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_a"}, {24'd0, data_a}, 32'd0);
    chk({name, "_b"}, {24'd0, data_b}, 32'd0);
    chk({name, "_op"}, {26'd0, opcode}, 32'd0);
    chk({name, "_tx"}, {24'd0, tx_data}, 32'd0);
    chk({name, "_start"}, {31'd0, tx_start}, 32'd0);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_to"}, {31'd0, timeout}, 32'd0);
  endtask

  task automatic async_reset();
    #3 rst = 1'b1;
    #1 check_all_zero("rst_async");
    rx_done = 1'b0; tick = 1'b0; tx_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1 check_all_zero("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Add: 5 + 3
    send3(8'h05, 8'h03, 8'h20);
    idle(1);
    chk("add_opcode", {26'd0, opcode}, 32'h20);
    chk("add_busy", {31'd0, busy}, 32'd1);
    idle(1);
    chk("add_result", {24'd0, tx_data}, 32'h08);
    chk("add_start_early", {31'd0, tx_start}, 32'd0);
    idle(1);
    chk("add_start", {31'd0, tx_start}, 32'd1);
    idle(1);
    chk("add_start_end", {31'd0, tx_start}, 32'd0);
    chk("add_busy_wait", {31'd0, busy}, 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    chk("add_busy_done", {31'd0, busy}, 32'd0);

    // AND with a dropped byte in WAIT_TX
    send3(8'hF0, 8'h0F, 8'h24);
    idle(4);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    idle(1);
    chk("and_a_kept", {24'd0, data_a}, 32'hF0);
    chk("and_result", {24'd0, tx_data}, 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);
    chk("and_idle", {31'd0, busy}, 32'd0);

    // Reset in WAIT_TX
    send3(8'h11, 8'h22, 8'h25);
    idle(4);
    async_reset();
    idle(5);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    idle(1);
    chk("rst_tx_reload", {24'd0, data_a}, 32'h3C);
    // Reset in WAIT_OP
    step(1'b1, 8'h77, 1'b0, 1'b0);
    idle(1);
    async_reset();
    idle(2);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    idle(1);
    chk("rst_op_reload", {24'd0, data_a}, 32'h99);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    step(1'b1, 8'h42, 1'b0, 1'b0);
    for (int i = 0; i < T_TICKS; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    chk("to_pulse", {31'd0, timeout}, 32'd1);
    chk("to_idle", {31'd0, busy}, 32'd0);
    idle(1);
    chk("to_pulse_end", {31'd0, timeout}, 32'd0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    idle(1);
    chk("to_reload", {24'd0, data_a}, 32'h5A);
    for (int i = 0; i < T_TICKS - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h6B, 1'b1, 1'b0);
    idle(1);
    chk("to_race_b", {24'd0, data_b}, 32'h6B);
    chk("to_race_none", {31'd0, timeout}, 32'd0);
`else
    step(1'b1, 8'h42, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    chk("noto_none", {31'd0, timeout}, 32'd0);
    step(1'b1, 8'h6B, 1'b0, 1'b0);
    idle(1);
    chk("noto_still_wait_b", {24'd0, data_b}, 32'h6B);
`endif
    step(1'b1, 8'h26, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);

    // Randomized traffic, including stray tx_done and bytes while busy
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0));
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
